fmap_frame_streamer: RTL
========================

Name: fmap_frame_streamer

Overview:
- Input stage directly upstream of lenet5_fix_weight.
- Accepts one I_SIZE1×I_SIZE1 image, one pixel per valid/ready transfer, and stores it in an internal frame RAM.
- Then drives the core's ce and i_fmap: one pixel per cycle, raster order, ce held high until the core reports o_classification_end.
- Returns to loading after end; the next frame can then be classified without a global reset.

Parameters:
- I_BW1, 8, pixel width in bits (matches core i_fmap).
- I_SIZE1, 32, image side length; N_PIX = I_SIZE1*I_SIZE1 pixels per frame.

Ports:
- clk  input  1  single system clock, rising edge.
- global_rst_n  input  1  asynchronous, active-low reset.
- i_pix_valid  input  1  load-side pixel valid.
- i_pix_data  input  I_BW1  load-side pixel, raster order, first pixel = row 0 col 0.
- o_pix_ready  output  1  load-side ready; transfer occurs when valid && ready.
- i_process_end  input  1  from core o_classification_end; single-cycle pulse.
- o_ce  output  1  clock enable to core ce.
- o_fmap  output  I_BW1  pixel to core i_fmap.
- o_frame_loaded  output  1  one-cycle pulse when pixel N_PIX-1 is written.
- o_stream_done  output  1  one-cycle pulse when pixel N_PIX-1 is presented on o_fmap.
- o_busy  output  1  high in STREAM and WAIT_END.

Behaviour:
- Reset (async assert, sync release): state LOAD, write/read counters 0.
- Reset values: o_pix_ready=1, o_ce=0, o_fmap=0, o_frame_loaded=0, o_stream_done=0, o_busy=0.
- Counters are CNT_W = clog2(N_PIX)+1 bits, so the terminal value N_PIX is representable. No wrap; counters clear only on a state change.
- State LOAD:
  - o_pix_ready=1.
  - Each transfer writes RAM[wr_cnt] and increments wr_cnt.
  - On the transfer with wr_cnt==N_PIX-1: pulse o_frame_loaded next cycle, drop o_pix_ready next cycle, go to STREAM.
  - i_process_end in LOAD is ignored.
- State STREAM:
  - o_ce=1 from the first STREAM cycle T0. o_ce must not deassert before WAIT_END ends.
  - RAM read is synchronous. Pixel k appears on o_fmap at cycle T0+1+k, for k=0..N_PIX-1.
  - o_stream_done pulses at cycle T0+N_PIX, coincident with the last pixel; then go to WAIT_END.
- State WAIT_END:
  - o_ce=1; o_fmap holds pixel N_PIX-1.
  - On i_process_end=1: next cycle o_ce=0, o_fmap=0, counters=0, o_pix_ready=1, state LOAD.
  - i_process_end during STREAM (early end) is treated identically, with the same transition to LOAD. Remaining pixels are abandoned.
- o_pix_ready=0 in STREAM and WAIT_END. The sender must hold data; nothing is dropped or overwritten.
- Reset mid-operation: immediate return to reset values. RAM contents are not cleared and not relied upon.
- o_busy = state is STREAM or WAIT_END.

Optional Feature:
- Macro: FMAP_DOUBLE_BUFFER_EN.
- Defined:
  - Two RAM banks with ping-pong operation.
  - Loading into the inactive bank continues while the other bank streams, so o_pix_ready stays high during STREAM and WAIT_END until the inactive bank is full.
  - A full inactive bank holds ready low until i_process_end.
  - On i_process_end with a full inactive bank: banks swap and STREAM restarts two cycles later, with o_ce low for exactly one cycle between frames.
  - Without a full inactive bank, the block returns to LOAD on the partially or empty loaded bank.
- Undefined: single bank, behaviour exactly as above.

Decomposition:
- Shared package (param_clog2.vh companion):
  - clog2 function.
  - N_PIX and CNT_W localparams.
  - State encoding LOAD=2'd0, STREAM=2'd1, WAIT_END=2'd2.
- Sub-module fmap_frame_ram:
  - Simple dual-port RAM, depth N_PIX, width I_BW1.
  - One sync write port and one sync-read port (one-cycle latency).
  - Instantiated twice under FMAP_DOUBLE_BUFFER_EN.

Test Plan (bench with I_SIZE1=4, N_PIX=16, I_BW1=8, stub core pulsing end):
- Reset pulse mid-sim -> all outputs 0 except o_pix_ready=1 in the same cycle as assertion (async).
- Load pixels 0x00..0x0F, valid always high -> o_frame_loaded after 16th transfer; o_ce rises; o_fmap=0x00..0x0F on 16 consecutive cycles after T0; o_stream_done with 0x0F.
- Valid toggled 1/0 every cycle during load -> only 16 handshakes counted; RAM order preserved; ready=0 once full.
- Stub pulses i_process_end 5 cycles after o_stream_done -> o_ce stays 1 and o_fmap=0x0F until then; next cycle o_ce=0, o_pix_ready=1. Second frame 0xF0..0xFF then streams correctly.
- i_process_end at k=7 of stream -> LOAD next cycle, o_ce=0, no o_stream_done. i_process_end during LOAD -> no effect.
- FMAP_DOUBLE_BUFFER_EN: frame B (0x20..0x2F) loaded during frame A streaming -> after end, o_ce low exactly 1 cycle, then 0x20..0x2F streamed.

Source files
------------

// File: rtl/fmap_frame_streamer_pkg.sv
// Shared definitions for the fmap frame streamer.
//   clog2        : ceiling log2 helper for address/counter sizing
//   DEF_*        : default frame geometry (32x32 image)
//   state_e      : controller state encoding
package fmap_frame_streamer_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    localparam int DEF_I_SIZE1 = 32;
    localparam int DEF_N_PIX   = DEF_I_SIZE1 * DEF_I_SIZE1;
    // One extra bit so the terminal count N_PIX is representable.
    localparam int DEF_CNT_W   = clog2(DEF_N_PIX) + 1;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        STREAM   = 2'd1,
        WAIT_END = 2'd2
    } state_e;

endpackage

// File: rtl/fmap_frame_streamer_if.sv
// Load-side pixel handshake (valid/ready, one pixel per transfer).
//   valid : pixel valid from the sender
//   data  : pixel value, raster order
//   ready : streamer can accept a pixel this cycle
interface fmap_frame_streamer_if #(
    parameter int I_BW1 = 8
);
    logic             valid;
    logic [I_BW1-1:0] data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fmap_frame_streamer_ram.sv
// Simple dual-port frame RAM: one synchronous write port, one synchronous
// read port with one-cycle latency. rdata holds its value when re is low.
//   clk           : clock
//   we/waddr/wdata: write port
//   re/raddr/rdata: read port
module fmap_frame_ram
    import fmap_frame_streamer_pkg::*;
#(
    parameter int DEPTH = DEF_N_PIX,
    parameter int W     = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/fmap_frame_streamer.sv
// Input stage for the LeNet-5 core: loads one I_SIZE1 x I_SIZE1 frame over a
// valid/ready port into frame RAM, then streams it to the core one pixel per
// cycle with ce held high until the core signals the end of classification.
//   clk, global_rst_n : clock, async active-low reset
//   pix (slave)       : load-side pixel handshake
//   i_process_end     : core classification-end pulse
//   o_ce, o_fmap      : core clock enable and pixel
//   o_frame_loaded    : pulse when pixel N_PIX-1 is written
//   o_stream_done     : pulse when pixel N_PIX-1 is on o_fmap
//   o_busy            : high while streaming or waiting for end
// Build option FMAP_DOUBLE_BUFFER_EN: two ping-pong banks, the next frame
// loads into the inactive bank while the active bank streams.
module fmap_frame_streamer
    import fmap_frame_streamer_pkg::*;
#(
    parameter int I_BW1   = 8,
    parameter int I_SIZE1 = DEF_I_SIZE1
) (
    input  logic                 clk,
    input  logic                 global_rst_n,
    fmap_frame_streamer_if.slave pix,
    input  logic                 i_process_end,
    output logic                 o_ce,
    output logic [I_BW1-1:0]     o_fmap,
    output logic                 o_frame_loaded,
    output logic                 o_stream_done,
    output logic                 o_busy
);

    localparam int N_PIX = I_SIZE1 * I_SIZE1;
    localparam int AW    = clog2(N_PIX);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_PIX - 1);
`ifdef FMAP_DOUBLE_BUFFER_EN
    localparam int NB = 2;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(N_PIX);
`else
    localparam int NB = 1;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic             ce_q, ce_d;
    logic             out_vld_q, out_vld_d;     // RAM read data is a valid pixel
    logic             ready_q, ready_d;
    logic             frame_loaded_q, frame_loaded_d;
    logic             stream_done_q, stream_done_d;
    logic             busy_q, busy_d;
    logic             bank_q, bank_d;           // bank being streamed
    logic             gap_q, gap_d;             // one ce-low cycle before a swapped restart

    logic xfer, rd_en, wr_bank;

    assign xfer  = pix.valid && ready_q;
    // An end pulse abandons the stream, so no further reads are issued.
    assign rd_en = (state_q == STREAM) && !i_process_end;

`ifdef FMAP_DOUBLE_BUFFER_EN
    assign wr_bank = (state_q == LOAD) ? bank_q : ~bank_q;
`else
    assign wr_bank = 1'b0;
`endif

    logic [NB-1:0]    ram_we, ram_re;
    logic [I_BW1-1:0] ram_rdata [NB];

    for (genvar b = 0; b < NB; b++) begin : g_bank
        assign ram_we[b] = xfer && (wr_bank == 1'(b));
        assign ram_re[b] = rd_en && (bank_q == 1'(b));
        fmap_frame_ram #(.DEPTH(N_PIX), .W(I_BW1), .AW(AW)) u_ram (
            .clk   (clk),
            .we    (ram_we[b]),
            .waddr (wr_cnt_q[AW-1:0]),
            .wdata (pix.data),
            .re    (ram_re[b]),
            .raddr (rd_cnt_q[AW-1:0]),
            .rdata (ram_rdata[b])
        );
    end

    always_comb begin
        state_d        = state_q;
        wr_cnt_d       = wr_cnt_q;
        rd_cnt_d       = rd_cnt_q;
        ce_d           = ce_q;
        out_vld_d      = out_vld_q;
        bank_d         = bank_q;
        gap_d          = 1'b0;
        frame_loaded_d = xfer && (wr_cnt_q == LAST);
        stream_done_d  = 1'b0;
        if (xfer) wr_cnt_d = wr_cnt_q + CNT_W'(1);

        unique case (state_q)
            LOAD: begin
                if (gap_q || frame_loaded_d) begin
                    state_d  = STREAM;
                    ce_d     = 1'b1;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                end
            end
            STREAM, WAIT_END: begin
                if (i_process_end) begin
                    state_d   = LOAD;
                    ce_d      = 1'b0;
                    out_vld_d = 1'b0;
                    rd_cnt_d  = '0;
`ifdef FMAP_DOUBLE_BUFFER_EN
                    // The inactive bank becomes active; if it is full it
                    // streams after the gap, otherwise loading resumes on it
                    // at the current write count.
                    bank_d = ~bank_q;
                    if (wr_cnt_d == FULL) begin
                        gap_d    = 1'b1;
                        wr_cnt_d = '0;
                    end
`else
                    wr_cnt_d = '0;
`endif
                end else if (state_q == STREAM) begin
                    out_vld_d = 1'b1;
                    rd_cnt_d  = rd_cnt_q + CNT_W'(1);
                    if (rd_cnt_q == LAST) begin
                        state_d       = WAIT_END;
                        stream_done_d = 1'b1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase

`ifdef FMAP_DOUBLE_BUFFER_EN
        ready_d = (state_d == LOAD) ? !gap_d : (wr_cnt_d != FULL);
`else
        ready_d = (state_d == LOAD);
`endif
        busy_d = (state_d != LOAD);
    end

    always_ff @(posedge clk or negedge global_rst_n) begin
        if (!global_rst_n) begin
            state_q        <= LOAD;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            ce_q           <= 1'b0;
            out_vld_q      <= 1'b0;
            ready_q        <= 1'b1;
            frame_loaded_q <= 1'b0;
            stream_done_q  <= 1'b0;
            busy_q         <= 1'b0;
            bank_q         <= 1'b0;
            gap_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            wr_cnt_q       <= wr_cnt_d;
            rd_cnt_q       <= rd_cnt_d;
            ce_q           <= ce_d;
            out_vld_q      <= out_vld_d;
            ready_q        <= ready_d;
            frame_loaded_q <= frame_loaded_d;
            stream_done_q  <= stream_done_d;
            busy_q         <= busy_d;
            bank_q         <= bank_d;
            gap_q          <= gap_d;
        end
    end

    assign pix.ready      = ready_q;
    assign o_ce           = ce_q;
    assign o_frame_loaded = frame_loaded_q;
    assign o_stream_done  = stream_done_q;
    assign o_busy         = busy_q;
`ifdef FMAP_DOUBLE_BUFFER_EN
    assign o_fmap = out_vld_q ? ram_rdata[bank_q] : '0;
`else
    assign o_fmap = out_vld_q ? ram_rdata[0] : '0;
`endif

endmodule
